bit_serial_adder: RTL

Bit-serial adder controller and datapath. Accepts two WIDTH-bit operands and a carry-in, then presents one bit pair per clock, LSB first, to a single one-bit full-adder cell. It accumulates the sum bits and the running carry, and returns a WIDTH-bit sum plus carry-out. It sits directly upstream of the one-bit full adder, trading latency for area wherever a parallel adder is too large.

---
 rtl/bit_serial_adder.sv | 117 +++++++++++
 1 files changed

// File: rtl/bit_serial_adder.sv
// rtl/bit_serial_adder.sv - LSB-first bit-serial adder with FSM control
// Optional subtract mode via SERIAL_ADD_SUB_EN (adds iSub port).
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iNum1,
  input  logic [WIDTH-1:0] iNum2,
  input  logic             iCin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             iSub,
`endif
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oSum,
  output logic             oCout
);

  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [KW-1:0] KLAST = KW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT            state;
  stateT            nextState;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic [WIDTH-1:0] sReg;
  logic [WIDTH-1:0] sumShift;
  logic [WIDTH-1:0] bLoad;
  logic             cReg;
  logic             cLoad;
  logic [KW-1:0]    kReg;
  logic             accept;
  logic             lastBit;
  logic             sBit;
  logic             cBit;

  assign accept  = iStart && ((state == IDLE) || (state == DONE));
  assign lastBit = (state == RUN) && (kReg == KLAST);

  // One-bit full-adder cell fed from the low bits of the shift registers.
  assign sBit = aReg[0] ^ bReg[0] ^ cReg;
  assign cBit = (aReg[0] & bReg[0]) | (aReg[0] & cReg) | (bReg[0] & cReg);

  always_comb begin
    sumShift = sReg >> 1;
    sumShift[WIDTH-1] = sBit;
  end

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction is a + ~b + 1, so the operand inversion and forced carry happen at load time.
  always_comb begin
    bLoad = iSub ? ~iNum2 : iNum2;
    cLoad = iSub ? 1'b1 : iCin;
  end
`else
  always_comb begin
    bLoad = iNum2;
    cLoad = iCin;
  end
`endif

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (iStart) nextState = RUN;
      RUN:     if (lastBit) nextState = DONE;
      DONE:    nextState = iStart ? RUN : IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    oBusy = (state == RUN);
    oDone = (state == DONE);
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      aReg  <= '0;
      bReg  <= '0;
      sReg  <= '0;
      cReg  <= 1'b0;
      kReg  <= '0;
      oSum  <= '0;
      oCout <= 1'b0;
    end else if (accept) begin
      aReg <= iNum1;
      bReg <= bLoad;
      cReg <= cLoad;
      kReg <= '0;
    end else if (state == RUN) begin
      aReg <= aReg >> 1;
      bReg <= bReg >> 1;
      cReg <= cBit;
      sReg <= sumShift;
      if (lastBit) begin
        oSum  <= sumShift;
        oCout <= cBit;
      end else begin
        kReg <= kReg + KW'(1);
      end
    end
  end

endmodule
